// File: rtl/stream_out_matrix_ping_pong_if.sv
// Matrix-in / element-out handshake bundle for stream_out_matrix_ping_pong.
// STREAM_OUT_INDEX_EN adds the out_row/out_col coordinate outputs.
interface stream_out_matrix_ping_pong_if #(
  parameter int BITS = 8,
  parameter int R    = 3,
  parameter int C    = 3
);
  localparam int RW = (R > 1) ? $clog2(R) : 1;
  localparam int CW = (C > 1) ? $clog2(C) : 1;

  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] a [R][C];
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] out_data;
  logic            out_last;
`ifdef STREAM_OUT_INDEX_EN
  logic [RW-1:0]   out_row;
  logic [CW-1:0]   out_col;
`endif

  modport slave (
    input  in_valid, a, out_ready,
    output in_ready, out_valid, out_data, out_last
`ifdef STREAM_OUT_INDEX_EN
    , output out_row, out_col
`endif
  );

  modport master (
    output in_valid, a, out_ready,
    input  in_ready, out_valid, out_data, out_last
`ifdef STREAM_OUT_INDEX_EN
    , input out_row, out_col
`endif
  );
endinterface

// File: rtl/stream_out_matrix_ping_pong.sv
// Ping-pong buffered matrix serializer: one R x C matrix in, R*C elements out row-major.
// Define STREAM_OUT_INDEX_EN to expose the (out_row, out_col) coordinates of out_data.
module stream_out_matrix_ping_pong #(
  parameter int BITS = 8,
  parameter int R    = 3,
  parameter int C    = 3
) (
  input logic clk,
  input logic rst,
  stream_out_matrix_ping_pong_if.slave bus
);
  localparam int N  = R * C;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (R > 1) ? $clog2(R) : 1;
  localparam int CW = (C > 1) ? $clog2(C) : 1;

  logic [BITS-1:0] bank [2][R][C];
  logic [1:0]      full;
  logic            wr_sel;
  logic            rd_sel;
  logic [IW-1:0]   idx;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;

  logic accept;
  logic xfer;
  logic at_last;

  assign bus.in_ready  = ~full[wr_sel];
  assign bus.out_valid = full[rd_sel];
  // row/col shadow idx so the element mux needs no divide or modulo
  assign bus.out_data  = bank[rd_sel][row][col];
  assign at_last       = (idx == IW'(N - 1));
  assign bus.out_last  = full[rd_sel] && at_last;
`ifdef STREAM_OUT_INDEX_EN
  assign bus.out_row   = row;
  assign bus.out_col   = col;
`endif

  assign accept = bus.in_valid && ~full[wr_sel];
  assign xfer   = full[rd_sel] && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < R; r++)
          for (int c = 0; c < C; c++)
            bank[b][r][c] <= '0;
      full   <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      idx    <= '0;
      row    <= '0;
      col    <= '0;
    end else begin
      // accept and drain always touch different banks, so both may act in one edge
      if (xfer) begin
        if (at_last) begin
          idx          <= '0;
          row          <= '0;
          col          <= '0;
          full[rd_sel] <= 1'b0;
          rd_sel       <= ~rd_sel;
        end else begin
          idx <= idx + IW'(1);
          if (col == CW'(C - 1)) begin
            col <= '0;
            row <= row + RW'(1);
          end else begin
            col <= col + CW'(1);
          end
        end
      end
      if (accept) begin
        bank[wr_sel] <= bus.a;
        full[wr_sel] <= 1'b1;
        wr_sel       <= ~wr_sel;
      end
    end
  end
endmodule
